spi_ram_slave_p: RTL and testbench
==================================

Name: spi_ram_slave_p

Overview:
- Parametrised successor to the fixed 10-bit SPI-slave-plus-RAM wrapper.
- Contains a self-contained SPI slave FSM and a single-port RAM behind one clock.
- Generalised in data width and address width, with command-error and frame-abort reporting and an optional address auto-increment burst mode.
- Sits at the chip pin level and is driven directly by an external SPI master (MOSI/SS_n/MISO).

Parameters:
- DATA_W, 8: RAM word width and frame payload width (frame = 2+DATA_W bits).
- ADDR_W, 8: RAM address width; depth = 2**ADDR_W; ADDR_W <= DATA_W is required.

Ports:
- clk  in  1  system clock; SPI bits sampled on rising edge.
- rst  in  1  asynchronous, active-high reset.
- MOSI  in  1  serial data in, MSB first.
- SS_n  in  1  active-low slave select.
- MISO  out  1  serial read data, MSB first.
- busy  out  1  high whenever FSM != IDLE.
- cmd_err  out  1  one-cycle pulse: read command inconsistent with read-address flag.
- frame_abort  out  1  one-cycle pulse: SS_n rose before frame completion.

Behaviour:
- Reset (async, rst=1): all outputs 0, FSM=IDLE, wr_addr=0, rd_addr=0, rd_flag=0, shift counters 0. RAM contents are not cleared.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX.
- Edge E0 (first edge with SS_n=0 in IDLE): go to CHK_CMD; no bit is taken.
- Edges E1..E(2+DATA_W): shift MOSI into rx_sr, MSB first.
  - At E1: bit=0 -> WRITE; bit=1 with rd_flag=0 -> READ_ADD; bit=1 with rd_flag=1 -> READ_DATA.
- Command = rx_sr[DATA_W+1:DATA_W]; payload = rx_sr[DATA_W-1:0]; RAM address uses payload[ADDR_W-1:0].
- Frame completes at E(2+DATA_W); the command executes at E(3+DATA_W):
  - 00: wr_addr <= payload.
  - 01: mem[wr_addr] <= payload.
  - 10: rd_addr <= payload; rd_flag <= 1.
  - 11: tx_reg <= mem[rd_addr]; rd_flag <= 0; enter TX.
- TX: MISO = tx_reg[DATA_W-1] from the cycle after E(3+DATA_W); tx_reg shifts left one bit per edge for DATA_W bits. After the last bit, MISO=0 and the FSM waits in TX for SS_n=1.
- After a write or read-address frame, the FSM waits with SS_n low and returns to IDLE on SS_n=1. Back-to-back frames require SS_n to be deasserted for at least one cycle.
- cmd_err: asserted when the second command bit contradicts the state (READ_ADD receives 1, or READ_DATA receives 0). The frame is then discarded: no RAM or register update, and the FSM waits for SS_n=1.
- SS_n rising in CHK_CMD/WRITE/READ_ADD/READ_DATA before frame completion: frame_abort pulse, no update, IDLE on the next edge. SS_n rising during TX: return to IDLE silently, MISO=0.
- Simultaneous SS_n rise and execute edge: the completed frame executes; no abort.
- Address arithmetic is modulo 2**ADDR_W; wrap from all-ones to 0.

Optional Feature:
- Macro: SPI_RAM_AUTO_INC_EN.
- Defined:
  - Command 01 post-increments wr_addr.
  - Command 11 post-increments rd_addr and keeps rd_flag=1, so consecutive 11 frames stream sequential words without re-sending the address.
- Undefined: addresses hold their value and rd_flag clears after 11 (legacy behaviour).

Decomposition:
- Package spi_ram_pkg: state enum; command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
- Sub-module spi_ram_core (parametrised DATA_W/ADDR_W): single-port synchronous RAM plus wr_addr/rd_addr/rd_flag registers. It takes a one-cycle exec strobe with cmd and payload, and returns tx data.
- The top level holds the SPI FSM, shift registers, counters and status pulses.

Test Plan:
- Defaults: frames 00_0x10, 01_0xA5, 10_0x10, 11_0x00 -> MISO serialises 1,0,1,0,0,1,0,1; busy deasserts after SS_n=1.
- AUTO_INC_EN: write address 0xFF, write data 0x11 then 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22 (wrap). Read address 0xFF, then two 11 frames -> 0x11 then 0x22.
- SS_n raised after 5 bits of a 01 frame -> frame_abort one cycle, RAM word unchanged, FSM in IDLE.
- With rd_flag=0, send frame 11 -> enters READ_ADD, second bit 1 -> cmd_err one cycle, rd_addr unchanged, MISO stays 0.
- rst pulsed mid-TX -> MISO=0, busy=0 immediately; rd_flag=0 afterwards; RAM contents retained.
- DATA_W=16, ADDR_W=10: write 0x3FF with 0xBEEF, read back -> 16 MISO bits of 0xBEEF; upper payload bits of the address frame are ignored.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared types and command encodings for the SPI-slave RAM block.
// This package is imported by spi_ram_core and spi_ram_slave_p.
package spi_ram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        TX
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram_core.sv
// Single-port RAM plus the write-address, read-address and read-flag registers.
// Each exec strobe applies one decoded command. Define SPI_RAM_AUTO_INC_EN to get post-increment bursts.
module spi_ram_core
    import spi_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exec,
    input  logic [1:0]        cmd,
    input  logic [DATA_W-1:0] payload,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_flag
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_flag_q, rd_flag_d;
    logic              mem_we;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        rd_flag_d = rd_flag_q;
        mem_we    = 1'b0;
        if (exec) begin
            case (cmd)
                CMD_WR_ADDR: wr_addr_d = payload[ADDR_W-1:0];
                CMD_WR_DATA: begin
                    mem_we = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
`endif
                end
                CMD_RD_ADDR: begin
                    rd_addr_d = payload[ADDR_W-1:0];
                    rd_flag_d = 1'b1;
                end
                default: begin
`ifdef SPI_RAM_AUTO_INC_EN
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
`else
                    rd_flag_d = 1'b0;
`endif
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            rd_flag_q <= 1'b0;
        end else begin
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            rd_flag_q <= rd_flag_d;
        end
    end

    // NOTE: the array has no reset so it maps onto block RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr_q] <= payload;
        end
        rd_data_q <= mem[rd_addr_q];
    end

    assign rd_data = rd_data_q;
    assign rd_flag = rd_flag_q;

endmodule

// File: rtl/spi_ram_slave_p.sv
// Pin-level SPI slave FSM in front of spi_ram_core. A frame is 2 command bits followed by DATA_W payload bits.
// Optional burst mode: define SPI_RAM_AUTO_INC_EN (handled inside spi_ram_core).
module spi_ram_slave_p
    import spi_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO,
    output logic busy,
    output logic cmd_err,
    output logic frame_abort
);

    localparam int FRAME_W  = DATA_W + 2;
    localparam int CNT_W    = $clog2(FRAME_W + 1);
    localparam int TX_CNT_W = $clog2(DATA_W + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]  rx_sr_q, rx_sr_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [TX_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic                miso_q, miso_d;
    logic                busy_q, busy_d;
    logic                cmd_err_q, cmd_err_d;
    logic                frame_abort_q, frame_abort_d;

    logic                exec;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_flag;
    logic                frame_full;
    logic                bad_cmd_bit;

    spi_ram_core #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .exec   (exec),
        .cmd    (rx_sr_q[FRAME_W-1:DATA_W]),
        .payload(rx_sr_q[DATA_W-1:0]),
        .rd_data(rd_data),
        .rd_flag(rd_flag)
    );

    assign frame_full  = (bit_cnt_q == CNT_W'(FRAME_W));
    // Second command bit must agree with the path chosen by the first bit and rd_flag.
    assign bad_cmd_bit = (bit_cnt_q == CNT_W'(1)) &&
                         (((state_q == READ_ADD) && MOSI) || ((state_q == READ_DATA) && !MOSI));

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_sr_d       = rx_sr_q;
        done_d        = done_q;
        tx_d          = tx_q;
        tx_cnt_d      = tx_cnt_q;
        miso_d        = miso_q;
        cmd_err_d     = 1'b0;
        frame_abort_d = 1'b0;
        exec          = 1'b0;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (!SS_n) begin
                    state_d   = CHK_CMD;
                    bit_cnt_d = '0;
                    rx_sr_d   = '0;
                    done_d    = 1'b0;
                end
            end
            CHK_CMD: begin
                if (SS_n) begin
                    frame_abort_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    rx_sr_d   = {rx_sr_q[FRAME_W-2:0], MOSI};
                    bit_cnt_d = CNT_W'(1);
                    if (!MOSI)        state_d = WRITE;
                    else if (rd_flag) state_d = READ_DATA;
                    else              state_d = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (done_q) begin
                    if (SS_n) state_d = IDLE;
                end else if (frame_full) begin
                    // Execute edge: a completed frame wins over a simultaneous SS_n rise.
                    exec = 1'b1;
                    if (state_q == READ_DATA) begin
                        state_d  = TX;
                        miso_d   = rd_data[DATA_W-1];
                        tx_d     = rd_data << 1;
                        tx_cnt_d = TX_CNT_W'(DATA_W - 1);
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (SS_n) begin
                    frame_abort_d = 1'b1;
                    state_d       = IDLE;
                end else if (bad_cmd_bit) begin
                    cmd_err_d = 1'b1;
                    done_d    = 1'b1;
                end else begin
                    rx_sr_d   = {rx_sr_q[FRAME_W-2:0], MOSI};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            TX: begin
                if (SS_n) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                end else if (tx_cnt_q != '0) begin
                    miso_d   = tx_q[DATA_W-1];
                    tx_d     = tx_q << 1;
                    tx_cnt_d = tx_cnt_q - TX_CNT_W'(1);
                end else begin
                    miso_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            rx_sr_q       <= '0;
            done_q        <= 1'b0;
            tx_q          <= '0;
            tx_cnt_q      <= '0;
            miso_q        <= 1'b0;
            busy_q        <= 1'b0;
            cmd_err_q     <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_sr_q       <= rx_sr_d;
            done_q        <= done_d;
            tx_q          <= tx_d;
            tx_cnt_q      <= tx_cnt_d;
            miso_q        <= miso_d;
            busy_q        <= busy_d;
            cmd_err_q     <= cmd_err_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign MISO        = miso_q;
    assign busy        = busy_q;
    assign cmd_err     = cmd_err_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_ram_slave_p.sv
// Directed bench for spi_ram_slave_p: an 8/8 instance and a 16/10 instance share clk and rst.
// Expectations follow the build: SPI_RAM_AUTO_INC_EN selects burst or legacy results.
module tb_spi_ram_slave_p;

    logic clk;
    logic rst;
    logic ss_a, mosi_a, miso_a, busy_a, err_a, abort_a;
    logic ss_b, mosi_b, miso_b, busy_b, err_b, abort_b;
    int   total;
    int   bad;
    logic [15:0] word;
    logic        tail;

    spi_ram_slave_p #(.DATA_W(8), .ADDR_W(8)) dut_a (
        .clk(clk), .rst(rst), .MOSI(mosi_a), .SS_n(ss_a),
        .MISO(miso_a), .busy(busy_a), .cmd_err(err_a), .frame_abort(abort_a)
    );

    spi_ram_slave_p #(.DATA_W(16), .ADDR_W(10)) dut_b (
        .clk(clk), .rst(rst), .MOSI(mosi_b), .SS_n(ss_b),
        .MISO(miso_b), .busy(busy_b), .cmd_err(err_b), .frame_abort(abort_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic ss, input logic mosi);
        if (sel == 0) begin
            ss_a = ss; mosi_a = mosi;
        end else begin
            ss_b = ss; mosi_b = mosi;
        end
    endtask

    task automatic start(input int sel);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0);
    endtask

    task automatic shift_bits(input int sel, input logic [17:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            drive(sel, 1'b0, bits[i]);
        end
    endtask

    task automatic wr_frame(input int sel, input logic [17:0] bits, input int n);
        start(sel);
        shift_bits(sel, bits, n);
        @(negedge clk);
        @(negedge clk);
        drive(sel, 1'b1, 1'b0);
        @(negedge clk);
    endtask

    task automatic rd_frame(input int sel, input logic [17:0] bits, input int n, input int dw,
                            output logic [15:0] w, output logic t);
        start(sel);
        shift_bits(sel, bits, n);
        @(negedge clk);
        w = '0;
        for (int k = 0; k < dw; k++) begin
            @(negedge clk);
            w[dw-1-k] = (sel == 0) ? miso_a : miso_b;
        end
        @(negedge clk);
        t = (sel == 0) ? miso_a : miso_b;
        drive(sel, 1'b1, 1'b0);
        @(negedge clk);
    endtask

    // Frame on dut_a expected to be rejected at its second command bit.
    task automatic err_frame(input logic [17:0] bits, input string tag);
        start(0);
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            if (i == 7) check({tag, "_pulse"}, err_a, 1'b1);
            if (i == 6) check({tag, "_one_cycle"}, err_a, 1'b0);
            drive(0, 1'b0, bits[i]);
        end
        @(negedge clk);
        @(negedge clk);
        check({tag, "_miso"}, miso_a, 1'b0);
        check({tag, "_busy_wait"}, busy_a, 1'b1);
        drive(0, 1'b1, 1'b0);
        @(negedge clk);
        check({tag, "_busy_idle"}, busy_a, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b1, 1'b0);
        drive(1, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(0, 1'b1, 1'b0);
        drive(1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_miso", miso_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_cmd_err", err_a, 1'b0);
        check("rst_abort", abort_a, 1'b0);
        check("rst_busy_b", busy_b, 1'b0);
        rst = 1'b0;

        // Basic write then read back of 0xA5 at 0x10.
        wr_frame(0, {2'b00, 8'h10}, 10);
        wr_frame(0, {2'b01, 8'hA5}, 10);
        wr_frame(0, {2'b10, 8'h10}, 10);
        rd_frame(0, {2'b11, 8'h00}, 10, 8, word, tail);
        check("read_a5", word, 16'h00A5);
        check("read_a5_tail", tail, 1'b0);
        check("read_busy_idle", busy_a, 1'b0);

        // Reset in the middle of TX.
        apply_reset();
        wr_frame(0, {2'b10, 8'h10}, 10);
        start(0);
        shift_bits(0, {2'b11, 8'h00}, 10);
        @(negedge clk);
        @(negedge clk);
        check("tx_bit7", miso_a, 1'b1);
        @(negedge clk);
        check("tx_bit6", miso_a, 1'b0);
        @(negedge clk);
        check("tx_bit5", miso_a, 1'b1);
        check("tx_busy", busy_a, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midtx_rst_miso", miso_a, 1'b0);
        check("midtx_rst_busy", busy_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b1, 1'b0);
        @(negedge clk);

        // rd_flag is clear after reset: a read-data frame is a command error, twice.
        err_frame({2'b11, 8'h33}, "err1");
        err_frame({2'b11, 8'h33}, "err2");

        // RAM survived the reset.
        wr_frame(0, {2'b10, 8'h10}, 10);
        rd_frame(0, {2'b11, 8'h00}, 10, 8, word, tail);
        check("retain_a5", word, 16'h00A5);

        // Abort a data-write frame after 5 bits.
        apply_reset();
        wr_frame(0, {2'b00, 8'h20}, 10);
        wr_frame(0, {2'b01, 8'h3C}, 10);
        start(0);
        shift_bits(0, 18'b01001, 5);
        @(negedge clk);
        drive(0, 1'b1, 1'b0);
        @(negedge clk);
        check("abort_pulse", abort_a, 1'b1);
        check("abort_idle", busy_a, 1'b0);
        @(negedge clk);
        check("abort_one_cycle", abort_a, 1'b0);
        wr_frame(0, {2'b10, 8'h20}, 10);
        rd_frame(0, {2'b11, 8'h00}, 10, 8, word, tail);
        check("abort_ram_kept", word, 16'h003C);

        // Writes at the top of the address space.
        apply_reset();
        wr_frame(0, {2'b00, 8'hFF}, 10);
        wr_frame(0, {2'b01, 8'h11}, 10);
        wr_frame(0, {2'b01, 8'h22}, 10);
        wr_frame(0, {2'b10, 8'hFF}, 10);
        rd_frame(0, {2'b11, 8'h00}, 10, 8, word, tail);
`ifdef SPI_RAM_AUTO_INC_EN
        check("burst_first", word, 16'h0011);
        rd_frame(0, {2'b11, 8'h00}, 10, 8, word, tail);
        check("burst_wrap", word, 16'h0022);
        check("burst_tail", tail, 1'b0);
`else
        check("legacy_overwrite", word, 16'h0022);
        err_frame({2'b11, 8'h00}, "legacy_flag");
`endif

        // Wide instance: address frames carry junk in the upper payload bits.
        wr_frame(1, {2'b00, 16'hFFFF}, 18);
        wr_frame(1, {2'b01, 16'hBEEF}, 18);
        wr_frame(1, {2'b10, 16'hABFF}, 18);
        rd_frame(1, {2'b11, 16'h0000}, 18, 16, word, tail);
        check("wide_beef", word, 16'hBEEF);
        check("wide_tail", tail, 1'b0);
        check("wide_busy_idle", busy_b, 1'b0);
        check("wide_no_err", err_b, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
